ssd_scan_driver: RTL
====================

// Module: ssd_scan_driver
// PURPOSE
//  Parametrised, time-multiplexed seven-segment display driver; successor to the fixed 4-digit scan logic in our top levels.
//  Scans NUM_DIGITS common-anode digits and hex-decodes one nibble per digit. Adds per-digit decimal point and per-digit enable.
//  Adds leading-zero suppression, PWM brightness, an anti-ghosting blank window and tear-free frame-synchronous input capture.
//  Sits beside display_controller in vga_top-class designs, fed by game/score logic.
// PARAMETERS
//  NUM_DIGITS     8   digits scanned, 1..8; digit 0 = least significant (rightmost)
//  SCAN_DIV_BITS  18  prescaler width; each digit slot lasts 2^SCAN_DIV_BITS clocks (2.62 ms @100 MHz)
//  PWM_BITS       4   brightness resolution; must be <= SCAN_DIV_BITS
//  BLANK_CYCLES   64  clocks at the start of each slot with all anodes off; must be < 2^SCAN_DIV_BITS
// PORTS
//  ClkPort      in   1             system clock (100 MHz)
//  Reset        in   1             asynchronous, active-high reset
//  digits_in    in   4*NUM_DIGITS  nibble i = [4i+3:4i] for digit i
//  dp_in        in   NUM_DIGITS    1 = decimal point lit on digit i
//  digit_en     in   NUM_DIGITS    1 = digit i may light; 0 = anode held off
//  lz_suppress  in   1             1 = blank leading zeros
//  brightness   in   PWM_BITS      duty control, sampled live; 0 = dark
//  An           out  NUM_DIGITS    anodes, active-low, registered
//  Cathodes     out  8             {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low, registered
//  frame_start  out  1             one-clock pulse when the shadow registers load
// BEHAVIOUR
//  Reset (async): prescaler=0, index=0, shadows=0, An=all 1s, Cathodes=8'hFF, frame_start=0.
//  Prescaler: free-running SCAN_DIV_BITS counter. tick = (prescaler == all 1s).
//  Digit index: on tick, index <= index+1; wraps NUM_DIGITS-1 -> 0.
//  Frame: on a tick where index == NUM_DIGITS-1, digits_in/dp_in/digit_en/lz_suppress load into shadow registers.
//    frame_start is registered high for exactly the following clock. Input changes mid-frame are never visible before then.
//  Output stage: An and Cathodes are registered from the current (index, prescaler, shadows, brightness).
//    Outputs lag index by 1 clock.
//  Anode lit iff all of the following hold:
//    prescaler >= BLANK_CYCLES;
//    phase < brightness, where phase = prescaler[SCAN_DIV_BITS-1 -: PWM_BITS];
//    digit_en_s[index] = 1;
//    digit not fully dark.
//    Max duty = (2^PWM_BITS-1)/2^PWM_BITS. Only the selected anode may be low; all others stay 1.
//  Leading-zero suppression: digit i (i>0) is suppressed iff lz_s=1 and nibbles NUM_DIGITS-1..i are all 0.
//    Digit 0 is never suppressed.
//  Suppressed digit: segments off. If dp_s[i]=1, anode lit and Cathodes=8'b1111111_0; else fully dark (anode off).
//  Segment map abcdefg (0=on):
//    0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100 6:0100000 7:0001111
//    8:0000000 9:0000100 A:0001000 b:1100000 C:0110001 d:1000010 E:0110000 F:0111000
//  Dp = ~dp_s[index].
//  Whenever the anode is off, Cathodes=8'hFF.
//  Reset mid-scan forces reset values on the same edge; the scan restarts at digit 0 with shadows=0 (blank until first frame).
// STRUCTURE
//  ssd_pkg: segment-map constant/function, SSD_OFF=8'hFF, anode/cathode polarity constants.
//  Sub-module ssd_hex_decoder: combinational nibble+dp -> 8-bit cathode pattern; instantiated once on the muxed nibble.
//  Top holds prescaler, index, shadows, suppression mask (computed combinationally from shadow), output regs.
// TESTING (bench params: NUM_DIGITS=4, SCAN_DIV_BITS=4, PWM_BITS=2, BLANK_CYCLES=2)
//  1 Reset asserted mid-slot with An low -> An=4'hF, Cathodes=8'hFF on that edge; frame_start=0.
//  2 digits_in=16'h0123, dp_in=0, en=4'hF, brightness=3:
//      after frame_start, slot 0 shows An=4'b1110, Cathodes=8'b0000110_1 for prescaler 2..11 (+1 clk lag);
//      An=4'hF for prescaler 0..1 and 12..15.
//  3 digits_in=16'h0050, lz=1, dp_in=4'b0100:
//      digit3 dark; digit2 An low with Cathodes=8'hFE; digit1 shows 5 (8'b0100100_1); digit0 shows 0.
//  4 digits_in changes 16'h1111->16'h2222 mid-frame -> remaining slots still show 1; 2 appears only after next frame_start.
//  5 digit_en=4'b0101 -> An[1], An[3] never low over 3 frames; digits 0,2 scan normally.
//  6 brightness=0 -> An stays 4'hF, Cathodes 8'hFF for whole frame; set to 1 -> lit only for prescaler 2..3 of each slot.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared constants and the hex segment map for the seven-segment scan driver.
// Cathode bytes are {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp} and active-low; anodes are active-low.
package ssd_pkg;

  localparam logic [7:0] SSD_OFF     = 8'hFF;
  localparam logic [7:0] SSD_DP_ONLY = 8'hFE;
  localparam logic       ANODE_ON    = 1'b0;
  localparam logic       ANODE_OFF   = 1'b1;

  // Segment pattern abcdefg for one hex nibble, 0 = segment lit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      default: seg = 7'b0111000;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational nibble + decimal point to active-low cathode pattern.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] cathodes
);

  assign cathodes = {hex_to_seg(nibble), ~dp};

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed seven-segment scan driver with frame-synchronous input capture,
// leading-zero suppression, PWM brightness and an anti-ghosting blank window.
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SCAN_DIV_BITS = 18,
  parameter int PWM_BITS      = 4,
  parameter int BLANK_CYCLES  = 64
) (
  input  logic                      ClkPort,
  input  logic                      Reset,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      lz_suppress,
  input  logic [PWM_BITS-1:0]       brightness,
  output logic [NUM_DIGITS-1:0]     An,
  output logic [7:0]                Cathodes,
  output logic                      frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [SCAN_DIV_BITS-1:0] prescaler;
  logic [IDX_W-1:0]         index;
  logic [4*NUM_DIGITS-1:0]  digits_s;
  logic [NUM_DIGITS-1:0]    dp_s;
  logic [NUM_DIGITS-1:0]    en_s;
  logic                     lz_s;

  logic tick;
  logic frame_end;

  assign tick      = &prescaler;
  assign frame_end = tick && (index == LAST_IDX);

  // Shadows only move at the frame boundary so a frame never mixes old and new data.
  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      prescaler   <= '0;
      index       <= '0;
      digits_s    <= '0;
      dp_s        <= '0;
      en_s        <= '0;
      lz_s        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      prescaler   <= prescaler + 1'b1;
      frame_start <= frame_end;
      if (tick) begin
        index <= (index == LAST_IDX) ? '0 : index + 1'b1;
      end
      if (frame_end) begin
        digits_s <= digits_in;
        dp_s     <= dp_in;
        en_s     <= digit_en;
        lz_s     <= lz_suppress;
      end
    end
  end

  // A digit is a leading zero when it and every more significant nibble are zero.
  logic [NUM_DIGITS-1:0] supp;
  logic                  upper_zero;

  always_comb begin
    supp       = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (digits_s[4*i +: 4] == 4'h0);
      if (i > 0) supp[i] = lz_s & upper_zero;
    end
  end

  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_en;
  logic                cur_supp;
  logic [7:0]          dec_cath;
  logic [PWM_BITS-1:0] phase;
  logic                lit;

  assign cur_nib  = digits_s[index*4 +: 4];
  assign cur_dp   = dp_s[index];
  assign cur_en   = en_s[index];
  assign cur_supp = supp[index];
  assign phase    = prescaler[SCAN_DIV_BITS-1 -: PWM_BITS];

  ssd_hex_decoder u_dec (
    .nibble   (cur_nib),
    .dp       (cur_dp),
    .cathodes (dec_cath)
  );

  assign lit = (prescaler >= SCAN_DIV_BITS'(BLANK_CYCLES)) && (phase < brightness) &&
               cur_en && !(cur_supp && !cur_dp);

  logic [NUM_DIGITS-1:0] an_next;
  logic [7:0]            cath_next;

  always_comb begin
    an_next   = {NUM_DIGITS{ANODE_OFF}};
    cath_next = SSD_OFF;
    if (lit) begin
      an_next[index] = ANODE_ON;
      cath_next      = cur_supp ? SSD_DP_ONLY : dec_cath;
    end
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      An       <= {NUM_DIGITS{ANODE_OFF}};
      Cathodes <= SSD_OFF;
    end else begin
      An       <= an_next;
      Cathodes <= cath_next;
    end
  end

endmodule
